// File: rtl/clk_gate_sched.sv
// Enable scheduler for a shared gated-clock domain: wake settle, per-requester ack, idle hysteresis.
// Optional build macro CLK_GATE_SCHED_DFX_EN adds the dfx_force_on override input.
module clk_gate_sched #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned WAKE_CYC = 4,
  parameter int unsigned HYST_CYC = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [N_REQ-1:0] req,
`ifdef CLK_GATE_SCHED_DFX_EN
  input  logic             dfx_force_on,
`endif
  output logic [N_REQ-1:0] ack,
  output logic             clk_en,
  output logic [1:0]       state_o
);

  localparam int unsigned MAX_CYC = (WAKE_CYC > HYST_CYC) ? WAKE_CYC : HYST_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_WAKE = 2'd1;
  localparam logic [1:0] ST_ON   = 2'd2;
  localparam logic [1:0] ST_HYST = 2'd3;

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] HYST_LOAD = (HYST_CYC > 0) ? CNT_W'(HYST_CYC - 1) : '0;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q;
  logic             any_req_c;
  logic             force_c;
  logic             granted_c;

  assign any_req_c = |req;

`ifdef CLK_GATE_SCHED_DFX_EN
  assign force_c = dfx_force_on;
`else
  assign force_c = 1'b0;
`endif

  // Next-state and shared down-counter; force only blocks the return to OFF.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (any_req_c) begin
          state_d = ST_WAKE;
          cnt_d   = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (cnt_q == '0) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ON: begin
        if (!any_req_c) begin
          if (HYST_CYC > 0) begin
            state_d = ST_HYST;
            cnt_d   = HYST_LOAD;
          end else if (force_c) begin
            state_d = ST_HYST;
            cnt_d   = '0;
          end else begin
            state_d = ST_OFF;
          end
        end
      end
      ST_HYST: begin
        if (any_req_c) begin
          state_d = ST_ON;
        end else if (cnt_q == '0) begin
          if (!force_c) begin
            state_d = ST_OFF;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      clk_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_en_q <= (state_d != ST_OFF);
    end
  end

  assign granted_c = (state_q == ST_ON) || (state_q == ST_HYST);
  assign state_o   = state_q;

`ifdef CLK_GATE_SCHED_DFX_EN
  assign clk_en = clk_en_q | force_c;
  assign ack    = force_c ? req : (req & {N_REQ{granted_c}});
`else
  assign clk_en = clk_en_q;
  assign ack    = req & {N_REQ{granted_c}};
`endif

endmodule

// File: tb/tb_clk_gate_sched.sv
// Testbench for clk_gate_sched: directed timing scenarios plus randomized traffic against
// a cycle-counting reference model (on/off, cycles since turn-on, consecutive idle cycles).
module tb_clk_gate_sched;

  localparam int unsigned N_REQ    = 4;
  localparam int unsigned WAKE_CYC = 4;
  localparam int unsigned HYST_CYC = 8;

  logic             clk = 1'b0;
  logic             rst_b = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic             dfx_force_on = 1'b0;
  logic [N_REQ-1:0] ack;
  logic             clk_en;
  logic [1:0]       state_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clk_gate_sched #(
    .N_REQ(N_REQ), .WAKE_CYC(WAKE_CYC), .HYST_CYC(HYST_CYC)
  ) dut (
    .clk(clk),
    .rst_b(rst_b),
    .req(req),
`ifdef CLK_GATE_SCHED_DFX_EN
    .dfx_force_on(dfx_force_on),
`endif
    .ack(ack),
    .clk_en(clk_en),
    .state_o(state_o)
  );

  // Reference model: clock on/off, edges since turn-on, consecutive idle edges once stable.
  logic        m_on   = 1'b0;
  int unsigned m_age  = 0;
  int unsigned m_idle = 0;

  always @(posedge clk) begin
    if (!rst_b) begin
      m_on <= 1'b0; m_age <= 0; m_idle <= 0;
    end else if (!m_on) begin
      if (|req) begin
        m_on <= 1'b1; m_age <= 0; m_idle <= 0;
      end
    end else if (m_age < WAKE_CYC) begin
      m_age <= m_age + 1;
    end else if (|req) begin
      m_idle <= 0;
    end else if (m_idle + 1 > HYST_CYC) begin
      if (dfx_force_on) m_idle <= HYST_CYC + 1;
      else              m_on   <= 1'b0;
    end else begin
      m_idle <= m_idle + 1;
    end
  end

  function automatic logic [1:0] exp_state();
    if (!m_on)                 return 2'd0;
    else if (m_age < WAKE_CYC) return 2'd1;
    else if (m_idle == 0)      return 2'd2;
    else                       return 2'd3;
  endfunction

  function automatic logic exp_en();
    return m_on | dfx_force_on;
  endfunction

  function automatic logic [N_REQ-1:0] exp_ack();
    if (dfx_force_on)                      return req;
    else if (m_on && m_age >= WAKE_CYC)    return req;
    else                                   return '0;
  endfunction

  task automatic test_reset();
    rst_b = 1'b0; req = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; @(negedge clk);
      n_cmp++; if (clk_en !== 1'b0) begin n_err++; $display("FAIL reset_clk_en cyc=%0d got=%b exp=0", i, clk_en); end
      n_cmp++; if (ack !== 4'h0) begin n_err++; $display("FAIL reset_ack cyc=%0d got=%h exp=0", i, ack); end
      n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL reset_state cyc=%0d got=%0d exp=0", i, state_o); end
    end
    rst_b = 1'b1; req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_wake();
    req = 4'b0001;
    @(negedge clk);
    n_cmp++; if (state_o !== 2'd0 || clk_en !== 1'b0) begin n_err++; $display("FAIL wake_pre got st=%0d en=%b exp st=0 en=0", state_o, clk_en); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; @(negedge clk);
      n_cmp++; if (state_o !== 2'd1) begin n_err++; $display("FAIL wake_state cyc=%0d got=%0d exp=1", i, state_o); end
      n_cmp++; if (clk_en !== 1'b1) begin n_err++; $display("FAIL wake_clk_en cyc=%0d got=%b exp=1", i, clk_en); end
      n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL wake_ack cyc=%0d got=%b exp=0000", i, ack); end
    end
    @(posedge clk); #1; @(negedge clk);
    n_cmp++; if (state_o !== 2'd2) begin n_err++; $display("FAIL wake_on_state got=%0d exp=2", state_o); end
    n_cmp++; if (ack !== 4'b0001) begin n_err++; $display("FAIL wake_on_ack got=%b exp=0001", ack); end
    // A second requester joining while ON is granted in the same cycle.
    req = 4'b0011; #1;
    n_cmp++; if (ack !== 4'b0011) begin n_err++; $display("FAIL join_ack got=%b exp=0011", ack); end
    req = 4'b0001;
    @(posedge clk); #1;
  endtask

  task automatic test_hyst();
    req = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1; @(negedge clk);
      n_cmp++; if (state_o !== 2'd3 || clk_en !== 1'b1) begin n_err++; $display("FAIL hyst_hold cyc=%0d got st=%0d en=%b exp st=3 en=1", i, state_o, clk_en); end
      n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL hyst_ack cyc=%0d got=%b exp=0000", i, ack); end
    end
    @(posedge clk); #1; @(negedge clk);
    n_cmp++; if (state_o !== 2'd0 || clk_en !== 1'b0) begin n_err++; $display("FAIL hyst_off got st=%0d en=%b exp st=0 en=0", state_o, clk_en); end
    @(posedge clk); #1;
  endtask

  task automatic test_rereq_hyst();
    req = 4'b0001;
    repeat (5) @(posedge clk);
    #1; @(negedge clk);
    n_cmp++; if (state_o !== 2'd2) begin n_err++; $display("FAIL rereq_on got=%0d exp=2", state_o); end
    req = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1; @(negedge clk);
      n_cmp++; if (state_o !== 2'd3 || clk_en !== 1'b1) begin n_err++; $display("FAIL rereq_hyst cyc=%0d got st=%0d en=%b exp st=3 en=1", i, state_o, clk_en); end
    end
    req = 4'b0100;
    @(posedge clk); #1; @(negedge clk);
    n_cmp++; if (state_o !== 2'd2) begin n_err++; $display("FAIL rereq_state got=%0d exp=2", state_o); end
    n_cmp++; if (ack !== 4'b0100 || clk_en !== 1'b1) begin n_err++; $display("FAIL rereq_ack got ack=%b en=%b exp ack=0100 en=1", ack, clk_en); end
    req = '0;
    repeat (9) @(posedge clk);
    #1; @(negedge clk);
    n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL rereq_off got=%0d exp=0", state_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    req = 4'b0001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(negedge clk);
    n_cmp++; if (state_o !== 2'd1) begin n_err++; $display("FAIL midrst_wake got=%0d exp=1", state_o); end
    @(posedge clk); #1; @(negedge clk);
    n_cmp++; if (state_o !== 2'd0 || clk_en !== 1'b0) begin n_err++; $display("FAIL midrst_off got st=%0d en=%b exp st=0 en=0", state_o, clk_en); end
    rst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; @(negedge clk);
      n_cmp++; if (state_o !== 2'd1 || clk_en !== 1'b1) begin n_err++; $display("FAIL midrst_rewake cyc=%0d got st=%0d en=%b exp st=1 en=1", i, state_o, clk_en); end
    end
    @(posedge clk); #1; @(negedge clk);
    n_cmp++; if (state_o !== 2'd2 || ack !== 4'b0001) begin n_err++; $display("FAIL midrst_on got st=%0d ack=%b exp st=2 ack=0001", state_o, ack); end
    req = '0;
    repeat (10) @(posedge clk);
    #1;
  endtask

`ifdef CLK_GATE_SCHED_DFX_EN
  task automatic test_dfx();
    req = 4'b1000; dfx_force_on = 1'b1; #1;
    @(negedge clk);
    n_cmp++; if (clk_en !== 1'b1 || ack !== 4'b1000) begin n_err++; $display("FAIL dfx_force got en=%b ack=%b exp en=1 ack=1000", clk_en, ack); end
    n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL dfx_state got=%0d exp=0", state_o); end
    repeat (5) @(posedge clk);
    #1; req = '0;
    repeat (20) @(posedge clk);
    #1; @(negedge clk);
    n_cmp++; if (state_o !== 2'd3 || clk_en !== 1'b1) begin n_err++; $display("FAIL dfx_hold got st=%0d en=%b exp st=3 en=1", state_o, clk_en); end
    dfx_force_on = 1'b0;
    @(posedge clk); #1; @(negedge clk);
    n_cmp++; if (state_o !== 2'd0 || clk_en !== 1'b0) begin n_err++; $display("FAIL dfx_release got st=%0d en=%b exp st=0 en=0", state_o, clk_en); end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst_b = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 7) == 0)
        req = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
`ifdef CLK_GATE_SCHED_DFX_EN
      if ($urandom_range(0, 31) == 0) dfx_force_on = ~dfx_force_on;
`endif
      @(negedge clk);
      n_cmp++; if (state_o !== exp_state()) begin n_err++; $display("FAIL rand_state cyc=%0d got=%0d exp=%0d", i, state_o, exp_state()); end
      n_cmp++; if (clk_en !== exp_en()) begin n_err++; $display("FAIL rand_clk_en cyc=%0d got=%b exp=%b", i, clk_en, exp_en()); end
      n_cmp++; if (ack !== exp_ack()) begin n_err++; $display("FAIL rand_ack cyc=%0d got=%b exp=%b", i, ack, exp_ack()); end
      @(posedge clk); #1;
    end
    rst_b = 1'b1; dfx_force_on = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wake();
    test_hyst();
    test_rereq_hyst();
    test_mid_reset();
`ifdef CLK_GATE_SCHED_DFX_EN
    test_dfx();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
